// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, forwarding selects and match bundle.
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } fsm_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic ex_a;
        logic ex_b;
        logic mem_a;
        logic mem_b;
        logic lu;
    } hazard_match_t;

    // The younger producer (EX) always wins over MEM.
    function automatic logic [1:0] fwd_pick(
        input logic ex_hit,
        input logic mem_hit
    );
        if (ex_hit)
            return FWD_MEM;
        else if (mem_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface pipeline_hazard_controller_if
    import pipeline_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);

    logic [REG_AW-1:0]      id_rs1_addr;
    logic [REG_AW-1:0]      id_rs2_addr;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic [REG_AW-1:0]      ex_rd_addr;
    logic                   ex_reg_write;
    logic                   ex_mem_read;
    logic [REG_AW-1:0]      mem_rd_addr;
    logic                   mem_reg_write;
    logic                   branch_taken;
    logic                   dmem_req;
    logic                   dmem_ready;

    logic                   pc_write_en;
    logic                   if_id_write_en;
    logic                   id_ex_write_en;
    logic                   ex_mem_write_en;
    logic                   if_id_flush;
    logic                   id_ex_bubble;
    logic [1:0]             fwd_a_sel;
    logic [1:0]             fwd_b_sel;
    logic [STALL_CNT_W-1:0] stall_count;
    logic                   mem_timeout_err;

    modport master (
        output id_rs1_addr, id_rs2_addr,
        output id_rs1_used, id_rs2_used,
        output ex_rd_addr, ex_reg_write,
        output ex_mem_read,
        output mem_rd_addr, mem_reg_write,
        output branch_taken,
        output dmem_req, dmem_ready,
        input  pc_write_en, if_id_write_en,
        input  id_ex_write_en, ex_mem_write_en,
        input  if_id_flush, id_ex_bubble,
        input  fwd_a_sel, fwd_b_sel,
        input  stall_count, mem_timeout_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr,
        input  id_rs1_used, id_rs2_used,
        input  ex_rd_addr, ex_reg_write,
        input  ex_mem_read,
        input  mem_rd_addr, mem_reg_write,
        input  branch_taken,
        input  dmem_req, dmem_ready,
        output pc_write_en, if_id_write_en,
        output id_ex_write_en, ex_mem_write_en,
        output if_id_flush, id_ex_bubble,
        output fwd_a_sel, fwd_b_sel,
        output stall_count, mem_timeout_err
    );

endinterface

// File: rtl/hazard_match_unit.sv
// Register-address comparators for forwarding and load-use detection.
// Purely combinational; x0 never produces a match.
module hazard_match_unit
    import pipeline_pkg::*;
(
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    output hazard_match_t     hit
);

    function automatic logic match(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic              we,
        input logic [REG_AW-1:0] rd
    );
        return used && we && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        hit       = '0;
        hit.ex_a  = match(rs1_used, rs1_addr,
                          ex_reg_write, ex_rd_addr);
        hit.ex_b  = match(rs2_used, rs2_addr,
                          ex_reg_write, ex_rd_addr);
        hit.mem_a = match(rs1_used, rs1_addr,
                          mem_reg_write, mem_rd_addr);
        hit.mem_b = match(rs2_used, rs2_addr,
                          mem_reg_write, mem_rd_addr);
        hit.lu    = ex_mem_read && (hit.ex_a || hit.ex_b);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall, flush and forwarding scheduler for the 5-stage pipeline.
// Freezes on dmem wait and traps a dmem timeout until reset.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 16
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_controller_if.slave hz
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hazard_match_t          m;
    fsm_state_e             state;
    fsm_state_e             state_nx;
    logic [CW-1:0]          wait_cnt;
    logic [CW-1:0]          wait_cnt_nx;
    logic                   frozen;
    logic                   pc_we;
    logic                   if_id_we;
    logic                   id_ex_we;
    logic                   ex_mem_we;
    logic                   flush;
    logic                   bubble;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   err;

    hazard_match_unit u_match (
        .rs1_addr      (hz.id_rs1_addr),
        .rs2_addr      (hz.id_rs2_addr),
        .rs1_used      (hz.id_rs1_used),
        .rs2_used      (hz.id_rs2_used),
        .ex_rd_addr    (hz.ex_rd_addr),
        .ex_reg_write  (hz.ex_reg_write),
        .ex_mem_read   (hz.ex_mem_read),
        .mem_rd_addr   (hz.mem_rd_addr),
        .mem_reg_write (hz.mem_reg_write),
        .hit           (m)
    );

    always_comb begin
        frozen = 1'b0;
        if (state == ST_RUN)
            frozen = hz.dmem_req && !hz.dmem_ready;
        else if (state == ST_MEM_WAIT)
            frozen = !hz.dmem_ready;
    end

    always_comb begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        if (!reset) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (state == ST_ERROR || frozen) begin
            pc_we = 1'b0;
        end else if (hz.branch_taken) begin
            // Squashed ID instruction makes load-use moot.
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            flush     = 1'b1;
            bubble    = 1'b1;
        end else if (m.lu) begin
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            bubble    = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        unique case (state)
            ST_RUN: begin
                if (hz.dmem_req && !hz.dmem_ready) begin
                    state_nx    = ST_MEM_WAIT;
                    wait_cnt_nx = CW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_nx    = ST_RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == CW'(MEM_TIMEOUT)) begin
                    state_nx = ST_ERROR;
                end else begin
                    wait_cnt_nx = wait_cnt + CW'(1);
                end
            end
            ST_ERROR: begin
                state_nx = ST_ERROR;
            end
            default: begin
                state_nx    = ST_RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            err      <= err || (state_nx == ST_ERROR);
            if (id_ex_we) begin
                fwd_a <= bubble ? FWD_RF : fwd_pick(m.ex_a, m.mem_a);
                fwd_b <= bubble ? FWD_RF : fwd_pick(m.ex_b, m.mem_b);
            end
            if (!pc_we && state != ST_ERROR && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.pc_write_en     = pc_we;
    assign hz.if_id_write_en  = if_id_we;
    assign hz.id_ex_write_en  = id_ex_we;
    assign hz.ex_mem_write_en = ex_mem_we;
    assign hz.if_id_flush     = flush;
    assign hz.id_ex_bubble    = bubble;
    assign hz.fwd_a_sel       = fwd_a;
    assign hz.fwd_b_sel       = fwd_b;
    assign hz.stall_count     = stall_cnt;
    assign hz.mem_timeout_err = err;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed literal checks
// plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_controller;
    import pipeline_pkg::*;

    localparam int TO = 4;
    localparam int SW = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.STALL_CNT_W(SW)) hz();

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (TO),
        .STALL_CNT_W (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model state: the outputs expected after the coming edge.
    bit known = 0;
    int m_fa = 0, m_fb = 0, m_stall = 0, m_run = 0;
    bit m_err = 0;
    bit ea, eb, ma, mb, lu, frz;
    logic [5:0] e_ctl;

    function automatic bit hit(input bit used, input logic [4:0] rs,
                               input bit we, input logic [4:0] rd);
        return used && we && rd != 0 && rd == rs;
    endfunction

    always @(negedge clk) begin
        ea = hit(hz.id_rs1_used, hz.id_rs1_addr,
                 hz.ex_reg_write, hz.ex_rd_addr);
        eb = hit(hz.id_rs2_used, hz.id_rs2_addr,
                 hz.ex_reg_write, hz.ex_rd_addr);
        ma = hit(hz.id_rs1_used, hz.id_rs1_addr,
                 hz.mem_reg_write, hz.mem_rd_addr);
        mb = hit(hz.id_rs2_used, hz.id_rs2_addr,
                 hz.mem_reg_write, hz.mem_rd_addr);
        lu = hz.ex_mem_read && (ea || eb);
        frz = !hz.dmem_ready && (hz.dmem_req || m_run > 0);
        // Order: pc, if_id, id_ex, ex_mem, flush, bubble.
        if (!reset)          e_ctl = 6'b000011;
        else if (m_err)      e_ctl = 6'b000000;
        else if (frz)        e_ctl = 6'b000000;
        else if (hz.branch_taken) e_ctl = 6'b111111;
        else if (lu)         e_ctl = 6'b001101;
        else                 e_ctl = 6'b111100;
        chk("ctrl", {26'd0, hz.pc_write_en, hz.if_id_write_en,
                     hz.id_ex_write_en, hz.ex_mem_write_en,
                     hz.if_id_flush, hz.id_ex_bubble}, 32'(e_ctl));
        if (known) begin
            chk("fwd_a", 32'(hz.fwd_a_sel), m_fa);
            chk("fwd_b", 32'(hz.fwd_b_sel), m_fb);
            chk("stall", 32'(hz.stall_count), m_stall);
            chk("err", 32'(hz.mem_timeout_err), 32'(m_err));
        end
        if (!reset) begin
            known = 1;
            m_fa = 0; m_fb = 0; m_stall = 0;
            m_run = 0; m_err = 0;
        end else begin
            if (e_ctl[3]) begin
                m_fa = e_ctl[0] ? 0 : (ea ? 1 : (ma ? 2 : 0));
                m_fb = e_ctl[0] ? 0 : (eb ? 1 : (mb ? 2 : 0));
            end
            if (!e_ctl[5] && !m_err && m_stall < (1 << SW) - 1)
                m_stall++;
            if (frz && !m_err) begin
                m_run++;
                if (m_run > TO) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1_addr = 0; hz.id_rs2_addr = 0;
        hz.id_rs1_used = 0; hz.id_rs2_used = 0;
        hz.ex_rd_addr = 0; hz.ex_reg_write = 0;
        hz.ex_mem_read = 0;
        hz.mem_rd_addr = 0; hz.mem_reg_write = 0;
        hz.branch_taken = 0;
        hz.dmem_req = 0; hz.dmem_ready = 0;
    endtask

    function automatic logic [3:0] ens();
        return {hz.pc_write_en, hz.if_id_write_en,
                hz.id_ex_write_en, hz.ex_mem_write_en};
    endfunction

    int pct;
    int ph;

    initial begin
        idle();
        reset = 0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_ctl", {hz.pc_write_en, hz.if_id_flush,
                        hz.id_ex_bubble}, 3'b011);
        chk("rst_regs", {hz.fwd_a_sel, hz.fwd_b_sel,
                         32'(hz.stall_count), hz.mem_timeout_err}, 0);
        cyc();
        reset = 1;
        // Forward from EX.
        hz.ex_rd_addr = 5; hz.ex_reg_write = 1;
        hz.id_rs1_addr = 5; hz.id_rs1_used = 1;
        @(negedge clk);
        chk("fwd_ex_en", ens(), 4'hf);
        cyc();
        chk("fwd_ex_a", hz.fwd_a_sel, 2'b01);
        // EX beats MEM, then x0 never forwards.
        hz.ex_rd_addr = 7; hz.mem_rd_addr = 7;
        hz.mem_reg_write = 1;
        hz.id_rs1_addr = 7; hz.id_rs2_addr = 7;
        hz.id_rs2_used = 1;
        cyc();
        chk("prio_b", hz.fwd_b_sel, 2'b01);
        chk("prio_a", hz.fwd_a_sel, 2'b01);
        hz.ex_rd_addr = 0; hz.id_rs1_addr = 0;
        hz.id_rs2_used = 0;
        cyc();
        chk("x0_a", hz.fwd_a_sel, 2'b00);
        // Load-use: one bubble, then forward from WB.
        idle();
        hz.ex_mem_read = 1; hz.ex_rd_addr = 3;
        hz.ex_reg_write = 1;
        hz.id_rs2_addr = 3; hz.id_rs2_used = 1;
        @(negedge clk);
        chk("lu_ctl", {hz.pc_write_en, hz.id_ex_bubble}, 2'b01);
        cyc();
        chk("lu_fwd", {hz.fwd_a_sel, hz.fwd_b_sel}, 4'b0000);
        chk("lu_stall", 32'(hz.stall_count), 1);
        hz.ex_mem_read = 0; hz.ex_reg_write = 0;
        hz.mem_rd_addr = 3; hz.mem_reg_write = 1;
        @(negedge clk);
        chk("lu_resume", hz.pc_write_en, 1);
        cyc();
        chk("lu_wb_b", hz.fwd_b_sel, 2'b10);
        // Branch beats load-use.
        hz.ex_mem_read = 1; hz.ex_reg_write = 1;
        hz.ex_rd_addr = 3; hz.branch_taken = 1;
        @(negedge clk);
        chk("br_ctl", {hz.pc_write_en, hz.if_id_flush,
                       hz.id_ex_bubble}, 3'b111);
        cyc();
        // Memory wait for 4 cycles, forwarding held.
        idle();
        hz.ex_rd_addr = 9; hz.ex_reg_write = 1;
        hz.id_rs1_addr = 9; hz.id_rs1_used = 1;
        hz.dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_ens", ens(), 4'h0);
            cyc();
        end
        chk("wait_hold", hz.fwd_a_sel, 2'b00);
        hz.dmem_ready = 1;
        @(negedge clk);
        chk("wait_go", ens(), 4'hf);
        cyc();
        chk("wait_stall", 32'(hz.stall_count), 5);
        chk("wait_fwd", hz.fwd_a_sel, 2'b01);
        // Timeout with ready stuck low.
        idle();
        hz.dmem_req = 1;
        repeat (5) cyc();
        chk("to_err", hz.mem_timeout_err, 1);
        hz.dmem_req = 0;
        @(negedge clk);
        chk("to_frozen", {ens(), hz.if_id_flush,
                          hz.id_ex_bubble}, 6'b0);
        cyc();
        chk("to_stall", 32'(hz.stall_count), 10);
        reset = 0;
        cyc();
        reset = 1;
        chk("to_rst", {32'(hz.stall_count), hz.mem_timeout_err}, 0);
        // Randomized traffic in phases.
        for (int i = 0; i < 4000; i++) begin
            ph = (i / 250) % 4;
            pct = (ph == 0) ? 100 : (ph == 1) ? 50 :
                  (ph == 2) ? 15 : 75;
            hz.id_rs1_addr = 5'($urandom_range(0, 3));
            hz.id_rs2_addr = 5'($urandom_range(0, 3));
            hz.id_rs1_used = 1'($urandom);
            hz.id_rs2_used = 1'($urandom);
            hz.ex_rd_addr = 5'($urandom_range(0, 3));
            hz.ex_reg_write = 1'($urandom);
            hz.ex_mem_read = $urandom_range(0, 99) < 40;
            hz.mem_rd_addr = 5'($urandom_range(0, 3));
            hz.mem_reg_write = 1'($urandom);
            hz.branch_taken = $urandom_range(0, 99) < 10;
            hz.dmem_req = (ph != 0) && $urandom_range(0, 99) < 30;
            hz.dmem_ready = $urandom_range(0, 99) < pct;
            reset = !((ph == 2) ? ($urandom_range(0, 39) == 0)
                                : ($urandom_range(0, 299) == 0));
            cyc();
        end
        reset = 1;
        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall, flush and forwarding scheduler for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Decides forwarding-mux selects for the instruction entering EX and generates PC and pipeline-register write enables and bubble/flush controls.
- Detects load-use hazards and taken-branch flushes, freezes the pipeline while data memory is busy, and traps a data-memory timeout.
- Sits beside the pipeline registers. Consumes register addresses and control bits from the ID, EX and MEM stages.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive dmem-wait cycles before the error trap; must be at least 2.
- STALL_CNT_W, 16: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk).
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd_addr  in  5  destination register of the instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes rd.
- branch_taken  in  1  EX resolved a taken branch or jump.
- dmem_req  in  1  MEM stage has an outstanding data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID register load enable.
- id_ex_write_en  out  1  ID/EX register load enable.
- ex_mem_write_en  out  1  EX/MEM and MEM/WB load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP into ID/EX.
- fwd_a_sel  out  2  EX operand A select: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result; registered.
- fwd_b_sel  out  2  EX operand B select, same encoding; registered.
- stall_count  out  STALL_CNT_W  saturating count of cycles with pc_write_en==0 while in RUN or MEM_WAIT.
- mem_timeout_err  out  1  sticky error flag; the pipeline stays frozen until reset.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. On reset: state=RUN, fwd_a_sel=fwd_b_sel=00, stall_count=0, wait counter=0, mem_timeout_err=0.
- While reset==0, combinational controls are: all write enables=0, if_id_flush=1, id_ex_bubble=1.
- Match definitions:
  - exA: id_rs1_used && ex_reg_write && ex_rd_addr!=0 && ex_rd_addr==id_rs1_addr.
  - memA: the same test against mem_rd_addr and mem_reg_write.
  - exB and memB: the same tests on rs2.
  - x0 never matches.
- Load-use: lu = ex_mem_read && (exA || exB).
- Control outputs are combinational from state and inputs. Priority, highest first:
  1. ERROR: all enables 0, no flush, no bubble.
  2. Freeze: (RUN && dmem_req && !dmem_ready) or (MEM_WAIT && !dmem_ready). All enables 0; flush and bubble 0.
  3. branch_taken: all enables 1, if_id_flush=1, id_ex_bubble=1. The load-use condition is ignored because the ID instruction is squashed.
  4. lu: pc_write_en=0, if_id_write_en=0, id_ex_write_en=1, id_ex_bubble=1, ex_mem_write_en=1.
  5. Otherwise all enables 1, flush and bubble 0.
- Forwarding registers load only when id_ex_write_en==1:
  - If bubbled: sel=00.
  - Otherwise fwd_a_sel = exA ? 01 : memA ? 10 : 00. EX has priority over MEM.
  - fwd_b_sel is computed the same way from exB and memB.
  - When id_ex_write_en==0, both selects hold their value.
- One load-use bubble suffices: next cycle the load is in MEM, memA or memB matches, and the select becomes 10.
- FSM transitions:
  - RUN -> MEM_WAIT when dmem_req && !dmem_ready; the wait counter is set to 1.
  - MEM_WAIT -> RUN on dmem_ready. The pipeline advances in that same cycle under priority rules 3-5.
  - MEM_WAIT: the counter increments each cycle. Counter==MEM_TIMEOUT && !dmem_ready -> ERROR, and mem_timeout_err=1.
  - ERROR exits only through reset.
- branch_taken asserted during a freeze is held by the frozen EX stage and acted on once the pipeline advances.
- stall_count increments when pc_write_en==0 in RUN or MEM_WAIT; it saturates at all-ones and is not incremented in ERROR.
- Reset asserted mid-wait or in ERROR returns to RUN at the next edge. A dmem_req still pending after reset re-enters MEM_WAIT normally.

Decomposition:
- Shared package (pipeline_pkg):
  - fsm state enum;
  - forwarding-select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - register address width 5.
- One natural sub-module: hazard_match_unit, the combinational exA/exB/memA/memB/lu comparators, reusable by the branch-compare forwarding path.

Test Plan:
- Forward from EX: ex_rd=5, ex_reg_write=1, id_rs1=5, id_rs1_used=1 -> next cycle fwd_a_sel=01; all enables 1.
- EX-over-MEM priority and x0: ex_rd=mem_rd=7, id_rs2=7 -> fwd_b_sel=01. Then ex_rd=0, id_rs1=0 -> fwd_a_sel=00.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3 -> for one cycle pc_write_en=0 and id_ex_bubble=1, and fwd sels load 00. In the next cycle (mem_rd=3) fwd_b_sel=10 and stall_count=1.
- Branch flush beats load-use: branch_taken=1 with the load-use condition active -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> all enables 0 for 4 cycles; the pipeline advances in the ready cycle; stall_count=4; fwd sels held.
- Timeout and reset: MEM_TIMEOUT=4 with dmem_ready stuck at 0 -> mem_timeout_err=1 and the pipeline frozen. Then reset=0 for one edge -> state RUN, err=0, stall_count=0.
